// File: rtl/tmds_decoder.sv
// tmds_decoder: one TMDS channel decoder with control-token word alignment.
// Define TMDS_LOSS_CNT_EN to add the loss_cnt output (saturating count of lock losses).
module tmds_decoder #(
    parameter int CTRL_RUN    = 8,
    parameter int SEARCH_WAIT = 2048,
    parameter int LOSS_WAIT   = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    output logic [7:0] dout,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       locked,
    output logic [3:0] offset
`ifdef TMDS_LOSS_CNT_EN
    ,
    output logic [7:0] loss_cnt
`endif
);
    localparam int RW = $clog2(CTRL_RUN) + 1;
    localparam int SW = $clog2(SEARCH_WAIT) + 1;
    localparam int LW = $clog2(LOSS_WAIT) + 1;
    typedef enum logic {SEARCH, LOCKED} state_t;
    state_t state;
    logic [9:0] din_prev, sym, sym_q;
    logic [19:0] win;
    logic [RW-1:0] run;
    logic [SW-1:0] s_tmr;
    logic [LW-1:0] l_tmr;
    logic [7:0] d, q;
    logic [6:0] x;
    logic [1:0] tok;
    logic is_tok;
    assign win = {din, din_prev};
    assign sym = 10'(win >> offset);
    assign is_tok = sym_q inside {10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    assign tok = sym_q == 10'b1101010100 ? 2'b00 :
                 sym_q == 10'b0010101011 ? 2'b01 :
                 sym_q == 10'b0101010100 ? 2'b10 : 2'b11;
    assign d = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    assign x = d[7:1] ^ d[6:0];
    assign q = {sym_q[8] ? x : ~x, d[0]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SEARCH;
            din_prev <= '0;
            sym_q    <= '0;
            run      <= '0;
            s_tmr    <= '0;
            l_tmr    <= '0;
            offset   <= '0;
            locked   <= 1'b0;
            de       <= 1'b0;
            dout     <= '0;
            ctrl     <= '0;
`ifdef TMDS_LOSS_CNT_EN
            loss_cnt <= '0;
`endif
        end else begin
            din_prev <= din;
            sym_q    <= sym;
            if (state == SEARCH) begin
                // a completed run takes priority over the dwell timeout
                if (is_tok && run == RW'(CTRL_RUN - 1)) begin
                    state  <= LOCKED;
                    locked <= 1'b1;
                    run    <= '0;
                    s_tmr  <= '0;
                end else if (s_tmr == SW'(SEARCH_WAIT - 1)) begin
                    offset <= offset == 4'd9 ? 4'd0 : offset + 4'd1;
                    run    <= '0;
                    s_tmr  <= '0;
                end else begin
                    run   <= is_tok ? run + RW'(run != '1) : '0;
                    s_tmr <= s_tmr + SW'(s_tmr != '1);
                end
            end else if (is_tok) begin
                ctrl  <= tok;
                de    <= 1'b0;
                dout  <= '0;
                l_tmr <= '0;
            end else if (l_tmr == LW'(LOSS_WAIT - 1)) begin
                state  <= SEARCH;
                locked <= 1'b0;
                de     <= 1'b0;
                dout   <= '0;
                ctrl   <= '0;
                l_tmr  <= '0;
                run    <= '0;
                s_tmr  <= '0;
`ifdef TMDS_LOSS_CNT_EN
                loss_cnt <= loss_cnt + 8'(loss_cnt != 8'hff);
`endif
            end else begin
                de    <= 1'b1;
                dout  <= q;
                l_tmr <= l_tmr + LW'(l_tmr != '1);
            end
        end
    end
endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: directed bench for tmds_decoder using a bit-shifted symbol stream.
module tb_tmds_decoder;
    localparam logic [9:0] T0 = 10'b1101010100;
    localparam logic [9:0] T1 = 10'b0010101011;
    localparam logic [9:0] D0 = 10'b0100000000;
    localparam logic [9:0] D1 = 10'b1000000001;
    localparam logic [9:0] D2 = 10'b0100000001;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [9:0] din = '0;
    logic [7:0] dout;
    logic [1:0] ctrl;
    logic de, locked;
    logic [3:0] offset;
`ifdef TMDS_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif
    logic [9:0] prev = '0;
    int sh = 0;
    int n_cmp = 0;
    int n_err = 0;
    int first = 0;

    tmds_decoder dut (
        .clk(clk), .rst_n(rst_n), .din(din), .dout(dout), .ctrl(ctrl),
        .de(de), .locked(locked), .offset(offset)
`ifdef TMDS_LOSS_CNT_EN
        , .loss_cnt(loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // serialise symbols and re-cut the bitstream into words delayed by sh bits
    task automatic step(input logic [9:0] s);
        logic [19:0] t;
        t = {s, prev} >> (10 - sh);
        din = t[9:0];
        prev = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din = '0;
        prev = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst_locked", locked, 0);
        check("rst_offset", offset, 0);
        check("rst_de", de, 0);
        check("rst_dout", dout, 0);
        check("rst_ctrl", ctrl, 0);
        // aligned stream at offset 0
        for (int i = 1; i <= 25; i++) begin
            step(i <= 20 ? T0 : i == 21 ? D0 : i == 22 ? D1 : D2);
            if (i == 9) check("t1_nolock9", locked, 0);
            if (i == 10) check("t1_lock10", locked, 1);
            if (i == 22) begin
                check("t1_de0", de, 0);
                check("t1_ctrl", ctrl, 2'b00);
            end
            if (i == 23) begin
                check("t1_de1", de, 1);
                check("t1_dout00", dout, 8'h00);
                check("t1_offset", offset, 0);
            end
            if (i == 24) check("t1_doutfc", dout, 8'hfc);
            if (i == 25) check("t1_dout03", dout, 8'h03);
        end
        // lock loss after LOSS_WAIT data-only cycles
        repeat (4) step(T0);
        for (int k = 1; k <= 4098; k++) begin
            step(D0);
            if (k == 4097) begin
                check("t3_locked_4095", locked, 1);
                check("t3_de_4095", de, 1);
            end
            if (k == 4098) begin
                check("t3_drop", locked, 0);
                check("t3_de", de, 0);
                check("t3_offset", offset, 0);
`ifdef TMDS_LOSS_CNT_EN
                check("t3_loss_cnt", loss_cnt, 1);
`endif
            end
        end
        // broken run of 7 does not lock; following run of 8 does
        do_reset();
        for (int i = 1; i <= 26; i++) begin
            step((i == 8 || i == 16 || i > 24) ? D0 : T0);
            if (i == 17) check("t4_run7a", locked, 0);
            if (i == 25) check("t4_run7b", locked, 0);
            if (i == 26) check("t4_run8", locked, 1);
        end
        // run completes on the final dwell cycle: lock wins over advance
        do_reset();
        for (int i = 1; i <= 2050; i++) begin
            step((i >= 2039 && i <= 2046) ? T0 : D0);
            if (i == 2047) check("t5_nolock", locked, 0);
            if (i == 2048) begin
                check("t5_lock", locked, 1);
                check("t5_offset", offset, 0);
            end
            if (i == 2050) check("t5_offset_hold", offset, 0);
        end
        // 3-bit misaligned stream with 200-token blanking per 1500-cycle line
        do_reset();
        sh = 3;
        for (int i = 1; i <= 6300; i++) begin
            step(((i - 1) % 1500) < 200 ? T1 : D2);
            if (locked && first == 0) first = i;
            if (i == 2047) check("t2_off_2047", offset, 0);
            if (i == 2048) check("t2_off_2048", offset, 1);
            if (i == 4095) check("t2_off_4095", offset, 1);
            if (i == 4096) check("t2_off_4096", offset, 2);
            if (i == 6144) check("t2_off_6144", offset, 3);
            if (i == 6152) check("t2_nolock", locked, 0);
            if (i == 6153) check("t2_lock", locked, 1);
            if (i == 6190) begin
                check("t2_ctrl", ctrl, 2'b01);
                check("t2_de0", de, 0);
                check("t2_off_lock", offset, 3);
            end
            if (i == 6300) begin
                check("t2_de1", de, 1);
                check("t2_dout", dout, 8'h03);
            end
        end
        check("t2_first_lock", first, 6153);
        // asynchronous reset mid-frame while locked
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_locked", locked, 0);
        check("t6_de", de, 0);
        check("t6_dout", dout, 0);
        check("t6_ctrl", ctrl, 0);
        check("t6_offset", offset, 0);
`ifdef TMDS_LOSS_CNT_EN
        check("t6_loss_cnt", loss_cnt, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sh = 0;
        prev = '0;
        repeat (3) step(D0);
        check("t6_post_locked", locked, 0);
        check("t6_post_offset", offset, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
- Receive-side counterpart of the DVI/TMDS transmit path: one TMDS channel decoder.
- Takes unaligned 10-bit parallel words from a 1:10 deserializer in the pixel clock domain.
- Finds symbol alignment using runs of control tokens in blanking, then decodes TMDS symbols to 8-bit data or 2-bit control with a data-enable.
- One instance per channel. Channel 0 ctrl carries {vsync, hsync}.

Parameters:
- CTRL_RUN, 8: consecutive control tokens at one offset required to declare lock.
- SEARCH_WAIT, 2048: cycles spent at each bit offset before advancing; must exceed one video line.
- LOSS_WAIT, 4096: cycles in LOCKED with no control token before lock is dropped.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- din  in  10  raw deserialized word; bit 0 received first
- dout  out  8  decoded pixel data
- ctrl  out  2  last decoded control value
- de  out  1  data enable; dout valid
- locked  out  1  alignment achieved
- offset  out  4  current bit offset, 0..9

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - din_prev=0, state=SEARCH, offset=0, counters=0.
- Window and symbol select:
  - win[19:0] = {din, din_prev}.
  - sym = win[offset+9 : offset], registered into sym_q (stage 1).
  - din_prev <= din every cycle.
- Control tokens:
  - 10'b1101010100 → 2'b00
  - 10'b0010101011 → 2'b01
  - 10'b0101010100 → 2'b10
  - 10'b1010101011 → 2'b11
  - Compare against sym_q.
- Data decode (stage 2):
  - d = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0].
  - q[0] = d[0].
  - For i=1..7: q[i] = sym_q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- Latency: din to dout/ctrl/de is exactly 2 clk cycles once locked.
- State SEARCH:
  - run increments on each control token and clears on any non-token.
  - timer increments every cycle.
  - run reaching CTRL_RUN → LOCKED; timer and run clear; offset held.
  - Otherwise, timer reaching SEARCH_WAIT-1 → offset advances (9 wraps to 0); run and timer clear.
  - If lock and timeout occur in the same cycle, lock wins and offset does not advance.
  - Outputs: de=0, dout=0, ctrl=0, locked=0.
- State LOCKED:
  - locked=1.
  - On a control token: ctrl <= token value, de <= 0, dout <= 0, timer clears.
  - Otherwise: de <= 1, dout <= q, ctrl holds its value, timer increments.
  - timer reaching LOSS_WAIT-1 → SEARCH with offset retained; run, timer, de, dout clear; ctrl clears; locked clears on the same edge.
- Offset change takes effect on the next sym_q capture. Symbols straddling the change are discarded by the run clear.
- Counter widths: $clog2 of the respective parameter, plus 1.
- Counters saturate, never wrap.

Optional Feature:
- Macro: TMDS_LOSS_CNT_EN.
- Defined:
  - Adds output port loss_cnt [7:0].
  - Counts LOCKED→SEARCH transitions, saturating at 255.
  - Cleared only by rst_n.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Aligned stream, offset 0: 20 × 10'b1101010100 then data symbol 10'b0100000000 (decodes to 8'h00) → locked=1 after CTRL_RUN+1 cycles; offset=0; ctrl=00; two cycles after data in, de=1 and dout=8'h00.
- Stream shifted by 3 bits, blanking of 200 tokens of 10'b0010101011 per 1500-cycle line → offset steps 0,1,2,3 every 2048 cycles; locks at offset=3; ctrl=01.
- Locked, then 4096 data-only cycles → locked drops at cycle 4096; offset retained; de=0. With TMDS_LOSS_CNT_EN defined, loss_cnt=1.
- SEARCH with 7 tokens, 1 data word, then 7 tokens → no lock, run clears. 8 consecutive tokens → lock.
- Token run completes on the exact SEARCH_WAIT-1 cycle → locked=1; offset unchanged.
- rst_n asserted mid-frame while locked → all outputs 0 immediately, without waiting for a clock edge. After release, state=SEARCH and offset=0.
